// File: rtl/n_queens_solver_if.sv
// rtl/n_queens_solver_if.sv - control/status bundle between a caller and n_queens_solver
//
// Purpose: groups the start/ready handshake, the fixed-queen row and all result
// outputs of the solver so they travel as one port.
//
// Signals:
//   start       caller -> solver  request a search (taken only while ready=1)
//   row_pos     caller -> solver  row of the queen pinned in column 0
//   ready       solver -> caller  idle, a start will be accepted
//   done        solver -> caller  one-cycle pulse at the end of a search
//   found       solver -> caller  last search produced a full placement
//   err         solver -> caller  last row_pos was out of range
//   board       solver -> caller  one-hot columns, column c at board[c*N +: N]
//   queen_rows  solver -> caller  row index per column, column c at [c*RW +: RW]
//   cycles      solver -> caller  cycles spent in the last search (saturating)
//   sol_count   solver -> caller  solutions counted (only with N_QUEENS_COUNT_ALL_EN)
//
// Modports: master (caller side), slave (solver side).
interface n_queens_solver_if #(
  parameter int N  = 8,
  parameter int CW = 16
);
  localparam int RW = $clog2(N);

  logic              start;
  logic [RW-1:0]     row_pos;
  logic              ready;
  logic              done;
  logic              found;
  logic              err;
  logic [N*N-1:0]    board;
  logic [N*RW-1:0]   queen_rows;
  logic [CW-1:0]     cycles;
`ifdef N_QUEENS_COUNT_ALL_EN
  logic [CW-1:0]     sol_count;

  modport master (
    output start, row_pos,
    input  ready, done, found, err, board, queen_rows, cycles, sol_count
  );

  modport slave (
    input  start, row_pos,
    output ready, done, found, err, board, queen_rows, cycles, sol_count
  );
`else
  modport master (
    output start, row_pos,
    input  ready, done, found, err, board, queen_rows, cycles
  );

  modport slave (
    input  start, row_pos,
    output ready, done, found, err, board, queen_rows, cycles
  );
`endif
endinterface

// File: rtl/n_queens_solver.sv
// rtl/n_queens_solver.sv - backtracking N-Queens solver with a fixed column-0 queen
//
// Purpose: given the row of a queen pinned in column 0, search column by column
// (rows ascending) for the lexicographically first full placement. One
// candidate square is evaluated per cycle; an exhausted column triggers a
// backtrack step, cascading while the previous column is also exhausted.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  n_queens_solver_if.slave: start/row_pos in; ready, done, found, err,
//        board, queen_rows, cycles (and sol_count) out
//
// Build option N_QUEENS_COUNT_ALL_EN: after each solution the search keeps
// backtracking to enumerate every completion; sol_count counts them and
// board/queen_rows show the most recent one (column 0 only if none).
module n_queens_solver #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  n_queens_solver_if.slave bus
);
  localparam int              RW      = $clog2(N);
  localparam logic [RW-1:0]   LAST    = RW'(N - 1);
  localparam logic [RW:0]     N_EXT   = (RW+1)'(N);
  localparam logic [CW-1:0]   CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, SEARCH, BACKTRACK, FIN} state_t;

  state_t          state;
  logic [RW-1:0]   c;
  logic [RW-1:0]   r;
  logic [RW-1:0]   rows [N];
  logic [N*N-1:0]  board_q;
  logic            ready_q;
  logic            done_q;
  logic            found_q;
  logic            err_q;
  logic [CW-1:0]   cycles_q;
  logic            safe;
  logic [N-1:0]    r_onehot;
`ifdef N_QUEENS_COUNT_ALL_EN
  logic [CW-1:0]   sol_q;
  logic [N*RW-1:0] snap_rows;
`else
  logic [N*RW-1:0] rows_packed;
`endif

  assign r_onehot = N'(1) << r;

  // Candidate (c, r) conflicts with a placed column k < c if it shares the row
  // or a diagonal (row distance equals column distance).
  always_comb begin
    safe = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (RW'(k) < c) begin
        if (rows[k] == r) begin
          safe = 1'b0;
        end else if (((rows[k] > r) ? rows[k] - r : r - rows[k]) == c - RW'(k)) begin
          safe = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      c        <= '0;
      r        <= '0;
      for (int k = 0; k < N; k++) rows[k] <= '0;
      board_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
`ifdef N_QUEENS_COUNT_ALL_EN
      sol_q     <= '0;
      snap_rows <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && cycles_q != CNT_MAX) cycles_q <= cycles_q + 1'b1;

      case (state)
        IDLE: begin
          if (bus.start && ready_q) begin
            ready_q  <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= '0;
            board_q  <= '0;
            for (int k = 0; k < N; k++) rows[k] <= '0;
`ifdef N_QUEENS_COUNT_ALL_EN
            sol_q     <= '0;
            snap_rows <= '0;
`endif
            if ({1'b0, bus.row_pos} >= N_EXT) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= FIN;
            end else begin
              rows[0]        <= bus.row_pos;
              board_q[N-1:0] <= N'(1) << bus.row_pos;
`ifdef N_QUEENS_COUNT_ALL_EN
              snap_rows[RW-1:0] <= bus.row_pos;
`endif
              c     <= RW'(1);
              r     <= '0;
              state <= SEARCH;
            end
          end
        end

        SEARCH: begin
          if (safe) begin
            rows[c] <= r;
`ifndef N_QUEENS_COUNT_ALL_EN
            for (int k = 0; k < N; k++) begin
              if (RW'(k) == c) board_q[k*N +: N] <= r_onehot;
            end
`endif
            if (c == LAST) begin
`ifdef N_QUEENS_COUNT_ALL_EN
              // Publish a snapshot; the working rows keep being backtracked.
              if (sol_q != CNT_MAX) sol_q <= sol_q + 1'b1;
              for (int k = 0; k < N; k++) begin
                if (k == N - 1) begin
                  snap_rows[k*RW +: RW] <= r;
                  board_q[k*N +: N]     <= r_onehot;
                end else begin
                  snap_rows[k*RW +: RW] <= rows[k];
                  board_q[k*N +: N]     <= N'(1) << rows[k];
                end
              end
              // The last column has only one free row, so no other r can succeed.
              state <= BACKTRACK;
`else
              found_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= FIN;
`endif
            end else begin
              c <= c + 1'b1;
              r <= '0;
            end
          end else if (r != LAST) begin
            r <= r + 1'b1;
          end else begin
            state <= BACKTRACK;
          end
        end

        BACKTRACK: begin
          rows[c] <= '0;
`ifndef N_QUEENS_COUNT_ALL_EN
          for (int k = 0; k < N; k++) begin
            if (RW'(k) == c) board_q[k*N +: N] <= '0;
          end
`endif
          c <= c - 1'b1;
          r <= rows[c - 1'b1] + 1'b1;
          if (c == RW'(1)) begin
            // Column 0 is pinned: nothing left to try.
            done_q <= 1'b1;
            state  <= FIN;
`ifdef N_QUEENS_COUNT_ALL_EN
            found_q <= (sol_q != '0);
`else
            found_q <= 1'b0;
`endif
          end else if (rows[c - 1'b1] == LAST) begin
            state <= BACKTRACK;
          end else begin
            state <= SEARCH;
          end
        end

        FIN: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;
  assign bus.board  = board_q;
  assign bus.cycles = cycles_q;

`ifdef N_QUEENS_COUNT_ALL_EN
  assign bus.queen_rows = snap_rows;
  assign bus.sol_count  = sol_q;
`else
  always_comb begin
    rows_packed = '0;
    for (int k = 0; k < N; k++) rows_packed[k*RW +: RW] = rows[k];
  end
  assign bus.queen_rows = rows_packed;
`endif
endmodule

// File: tb/tb_n_queens_solver.sv
// tb/tb_n_queens_solver.sv - directed self-checking bench for n_queens_solver (N = 4, 6, 8)
module tb_n_queens_solver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  n_queens_solver_if #(.N(4), .CW(16)) if4 ();
  n_queens_solver_if #(.N(6), .CW(16)) if6 ();
  n_queens_solver_if #(.N(8), .CW(16)) if8 ();

  n_queens_solver #(.N(4), .CW(16)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  n_queens_solver #(.N(6), .CW(16)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));
  n_queens_solver #(.N(8), .CW(16)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  logic         o_ready, o_done, o_found, o_err;
  logic [255:0] o_board;
  logic [63:0]  o_qrows;
  logic [15:0]  o_cycles;
  logic [15:0]  o_sol;

  task automatic sample(input int n);
    o_board = '0;
    o_qrows = '0;
    o_sol   = '0;
    case (n)
      4: begin
        o_ready = if4.ready; o_done = if4.done; o_found = if4.found; o_err = if4.err;
        o_board[15:0] = if4.board; o_qrows[7:0] = if4.queen_rows; o_cycles = if4.cycles;
`ifdef N_QUEENS_COUNT_ALL_EN
        o_sol = if4.sol_count;
`endif
      end
      6: begin
        o_ready = if6.ready; o_done = if6.done; o_found = if6.found; o_err = if6.err;
        o_board[35:0] = if6.board; o_qrows[17:0] = if6.queen_rows; o_cycles = if6.cycles;
`ifdef N_QUEENS_COUNT_ALL_EN
        o_sol = if6.sol_count;
`endif
      end
      default: begin
        o_ready = if8.ready; o_done = if8.done; o_found = if8.found; o_err = if8.err;
        o_board[63:0] = if8.board; o_qrows[23:0] = if8.queen_rows; o_cycles = if8.cycles;
`ifdef N_QUEENS_COUNT_ALL_EN
        o_sol = if8.sol_count;
`endif
      end
    endcase
  endtask

  task automatic drive(input int n, input logic s, input logic [3:0] rp);
    case (n)
      4:       begin if4.start = s; if4.row_pos = rp[1:0]; end
      6:       begin if6.start = s; if6.row_pos = rp[2:0]; end
      default: begin if8.start = s; if8.row_pos = rp[2:0]; end
    endcase
  endtask

  // Start a search and follow it to its done pulse; checks the handshake and
  // the cycle count against the bench's own cycle measurement. poke holds
  // start high one extra cycle with a different row; at_done raises start in
  // the done cycle.
  task automatic run(input string nm, input int n, input logic [3:0] rp,
                     input bit poke, input bit at_done, output int lat);
    @(negedge clk); drive(n, 1'b1, rp);
    @(negedge clk); drive(n, poke, poke ? 4'd0 : rp);
    lat = 1;
    sample(n);
    while (!o_done && lat < 10000) begin
      @(negedge clk);
      lat++;
      if (lat == 2) drive(n, 1'b0, rp);
      sample(n);
    end
    drive(n, 1'b0, rp);
    n_cmp++;
    if (o_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done: got %b after %0d cycles, want 1", nm, o_done, lat);
      return;
    end
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ready_in_done: got %b want 0", nm, o_ready);
    end
    if (at_done) drive(n, 1'b1, 4'd0);
    @(negedge clk);
    sample(n);
    if (at_done) drive(n, 1'b0, rp);
    n_cmp++;
    if (o_ready !== 1'b1 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ready_after_done: got ready=%b done=%b want ready=1 done=0", nm, o_ready, o_done);
    end
    n_cmp++;
    if (o_cycles !== 16'(lat)) begin
      n_bad++;
      $display("FAIL %s cycles: got %0d want %0d", nm, o_cycles, lat);
    end
  endtask

  // nibs holds the expected row of column k in nibble k; ncols columns are placed.
  task automatic check_final(input string nm, input int n, input logic [63:0] nibs,
                             input int ncols, input logic ef, input logic ee);
    logic [255:0] eb;
    logic [63:0]  eq;
    int           rw;
    int           rowv;
    rw = (n == 4) ? 2 : 3;
    eb = '0;
    eq = '0;
    for (int k = 0; k < ncols; k++) begin
      rowv = int'(nibs[k*4 +: 4]);
      eb[k*n + rowv] = 1'b1;
      eq = eq | (64'(rowv) << (k * rw));
    end
    n_cmp++;
    if (o_found !== ef) begin
      n_bad++;
      $display("FAIL %s found: got %b want %b", nm, o_found, ef);
    end
    n_cmp++;
    if (o_err !== ee) begin
      n_bad++;
      $display("FAIL %s err: got %b want %b", nm, o_err, ee);
    end
    n_cmp++;
    if (o_board !== eb) begin
      n_bad++;
      $display("FAIL %s board: got %h want %h", nm, o_board[63:0], eb[63:0]);
    end
    n_cmp++;
    if (o_qrows !== eq) begin
      n_bad++;
      $display("FAIL %s queen_rows: got %h want %h", nm, o_qrows, eq);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? 4 : ((i == 1) ? 6 : 8);
      sample(n);
      n_cmp++;
      if (o_ready !== 1'b1 || o_done !== 1'b0 || o_found !== 1'b0 || o_err !== 1'b0 ||
          o_board !== '0 || o_qrows !== '0 || o_cycles !== '0 || o_sol !== '0) begin
        n_bad++;
        $display("FAIL reset_n%0d: got ready=%b done=%b found=%b err=%b board=%h rows=%h cycles=%0d want 1,0,0,0,0,0,0",
                 n, o_ready, o_done, o_found, o_err, o_board[63:0], o_qrows, o_cycles);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_first_solution();
    int lat;
    run("n8_r0", 8, 4'd0, 1'b0, 1'b0, lat);
`ifdef N_QUEENS_COUNT_ALL_EN
    n_cmp++;
    if (o_sol !== 16'd4 || o_found !== 1'b1) begin
      n_bad++;
      $display("FAIL n8_r0 sol_count: got %0d found=%b want 4 found=1", o_sol, o_found);
    end
`else
    check_final("n8_r0", 8, 64'h31625740, 8, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_no_solution();
    int lat;
    run("n4_r0", 4, 4'd0, 1'b0, 1'b0, lat);
    check_final("n4_r0", 4, 64'h0, 1, 1'b0, 1'b0);
    run("n4_r1", 4, 4'd1, 1'b0, 1'b0, lat);
    check_final("n4_r1", 4, 64'h2031, 4, 1'b1, 1'b0);
`ifdef N_QUEENS_COUNT_ALL_EN
    n_cmp++;
    if (o_sol !== 16'd1) begin
      n_bad++;
      $display("FAIL n4_r1 sol_count: got %0d want 1", o_sol);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    run("n6_r3", 6, 4'd3, 1'b1, 1'b1, lat);
    check_final("n6_r3", 6, 64'h251403, 6, 1'b1, 1'b0);
    run("n6_r0", 6, 4'd0, 1'b0, 1'b0, lat);
    check_final("n6_r0", 6, 64'h0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_err();
    int lat;
    run("n6_r7", 6, 4'd7, 1'b0, 1'b0, lat);
    n_cmp++;
    if (lat > 2) begin
      n_bad++;
      $display("FAIL n6_r7 err_latency: got %0d cycles want <= 2", lat);
    end
    check_final("n6_r7", 6, 64'h0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk); drive(8, 1'b1, 4'd0);
    @(negedge clk); drive(8, 1'b0, 4'd0);
    repeat (19) @(negedge clk);
    sample(8);
    n_cmp++;
    if (o_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got ready=%b want 0", o_ready);
    end
    rst = 1'b0;
    #1;
    sample(8);
    n_cmp++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || o_found !== 1'b0 || o_err !== 1'b0 ||
        o_board !== '0 || o_qrows !== '0 || o_cycles !== '0) begin
      n_bad++;
      $display("FAIL abort_reset: got ready=%b done=%b found=%b err=%b board=%h rows=%h cycles=%0d want 1,0,0,0,0,0,0",
               o_ready, o_done, o_found, o_err, o_board[63:0], o_qrows, o_cycles);
    end
    drive(8, 1'b1, 4'd5);
    repeat (3) @(negedge clk);
    drive(8, 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sample(8);
    n_cmp++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || o_board !== '0) begin
      n_bad++;
      $display("FAIL abort_start_ignored: got ready=%b done=%b board=%h want 1,0,0", o_ready, o_done, o_board[63:0]);
    end
    run("n8_r0_again", 8, 4'd0, 1'b0, 1'b0, lat);
`ifdef N_QUEENS_COUNT_ALL_EN
    n_cmp++;
    if (o_sol !== 16'd4) begin
      n_bad++;
      $display("FAIL n8_r0_again sol_count: got %0d want 4", o_sol);
    end
`else
    check_final("n8_r0_again", 8, 64'h31625740, 8, 1'b1, 1'b0);
`endif
  endtask

`ifdef N_QUEENS_COUNT_ALL_EN
  task automatic test_count_all();
    int lat;
    int exp_cnt [8];
    exp_cnt = '{4, 8, 16, 18, 18, 16, 8, 4};
    for (int i = 0; i < 8; i++) begin
      run("n8_count", 8, 4'(i), 1'b0, 1'b0, lat);
      n_cmp++;
      if (o_sol !== 16'(exp_cnt[i]) || o_found !== 1'b1) begin
        n_bad++;
        $display("FAIL n8_count_r%0d: got sol_count=%0d found=%b want %0d found=1", i, o_sol, o_found, exp_cnt[i]);
      end
    end
  endtask
`endif

  initial begin
    drive(4, 1'b0, 4'd0);
    drive(6, 1'b0, 4'd0);
    drive(8, 1'b0, 4'd0);
    test_reset();
    test_first_solution();
    test_no_solution();
    test_back_to_back();
    test_err();
    test_reset_abort();
`ifdef N_QUEENS_COUNT_ALL_EN
    test_count_all();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/n_queens_solver.md
Name: n_queens_solver

Overview:
- Parametrised N-Queens solver. The caller supplies the row of a fixed queen in column 0.
- The block performs a hardware backtracking search for the lexicographically first completion and exposes the board as one-hot column registers.
- It is the general successor to the fixed 8x8 queen placer: any board size N, true backtracking, explicit done/found/error status.
- It sits behind the same START/READY-style control as the 8x8 design.

Parameters:
- N, 8, board size (columns = rows = N); legal range 4..16.
- RW, $clog2(N), width of a row index; derived, not overridden.
- CW, 16, width of the cycle and solution counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a search; sampled only while ready=1.
- row_pos  in  RW  row of the fixed queen in column 0; captured on accepted start.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse when the search ends.
- found  out  1  last search produced a complete placement.
- err  out  1  last row_pos was >= N; no search was run.
- board  out  N*N  one-hot column registers; column c occupies board[c*N +: N]; bit r = queen in row r.
- queen_rows  out  N*RW  row index per column, same ordering as board.
- cycles  out  CW  cycles spent in the last search (saturating).

Behaviour:
- Reset (rst=0, async): ready=1; done=0; found=0; err=0; board=0; queen_rows=0; cycles=0; FSM=IDLE. Any state aborts immediately, including mid-search.
- IDLE:
  - start=1 captures row_pos, clears board/found/err/cycles, and sets ready=0 on the next edge.
  - If row_pos >= N: go to FIN with err=1.
  - Otherwise place col0 = row_pos, set c=1, r=0, go to SEARCH.
  - start while ready=0 is ignored.
- SEARCH evaluates exactly one candidate (c, r) per cycle.
  - safe = for all k < c: row[k] != r and |row[k]-r| != c-k. Computed combinationally over placed columns only; unsigned difference by compare-and-subtract.
  - If safe: store row[c]=r and set board column c one-hot.
    - If c == N-1: go to FIN with found=1.
    - Else c <= c+1, r <= 0.
  - If unsafe and r < N-1: r <= r+1.
  - If unsafe and r == N-1: go to BACKTRACK.
- BACKTRACK, one cycle per step: clear board column c; c <= c-1; r <= row[c-1]+1.
  - If c-1 == 0: go to FIN with found=0, since column 0 is fixed and never moves.
  - If row[c-1] == N-1: stay in BACKTRACK (cascade), clearing that column too.
  - Otherwise return to SEARCH.
- FIN: done=1 for one cycle; ready=1 from the next cycle; go to IDLE.
  - board and queen_rows hold their final values until the next accepted start.
  - On no-solution or err, board is left with only column 0 set, or all zero for err.
- cycles counts every cycle from the cycle after start acceptance to FIN inclusive, and saturates at 2^CW-1.
- A start asserted in the same cycle as done is ignored (ready=0 in FIN).

Optional Feature:
- Macro: N_QUEENS_COUNT_ALL_EN.
- Defined:
  - Adds output sol_count (CW bits), reset to 0 and cleared on an accepted start.
  - On a safe placement at c == N-1, the FSM increments sol_count and enters BACKTRACK instead of FIN. This enumerates every solution with the given column-0 row.
  - FIN is entered only when backtracking reaches column 0. found=1 iff sol_count>0.
  - board holds the last solution found, or column 0 only if there is none.
- Undefined: no sol_count port; stop at first solution as above.

Test Plan:
- N=8, row_pos=0 -> done pulse, found=1, queen_rows = 0,4,7,5,2,6,1,3; ready=1 one cycle after done.
- N=4, row_pos=0 -> found=0, board has only column 0 row 0. Then row_pos=1 -> found=1, queen_rows = 1,3,0,2.
- N=6, row_pos=3 -> queen_rows = 3,0,4,1,5,2. Then row_pos=0 -> found=0.
- N=8, row_pos=9 is impossible at RW=3, so use N=6 with row_pos=7 -> err=1, found=0, board=0, done within 2 cycles of start.
- N=8 search in progress; pull rst low at cycle 20 -> all outputs at reset values immediately; start ignored until rst high; a new search then gives the same result as a clean run.
- With N_QUEENS_COUNT_ALL_EN, N=8:
  - row_pos 0..7 -> sol_count = 4,8,16,18,18,16,8,4.
  - N=4, row_pos=1 -> sol_count=1.
